// File: rtl/tfl_pkg.sv
// tfl_pkg: shared types and helpers for the traffic-light controllers.
//   tfl_state_e : controller phase encoding (CLEAR only with TFL_ALL_RED_EN)
//   LT_G/LT_Y/LT_R : bit offsets of green/yellow/red within a 3-bit lamp group
//   rr_next()   : round-robin search for the next approach with demand
// Configuration macro: TFL_ALL_RED_EN (adds the all-red CLEAR phase).
package tfl_pkg;

   localparam int unsigned LT_G   = 0;
   localparam int unsigned LT_Y   = 1;
   localparam int unsigned LT_R   = 2;

   // Widest demand vector rr_next() can scan.
   localparam int unsigned RR_MAX = 32;

   typedef enum logic [1:0] {
      ST_GREEN  = 2'd0,
      ST_EXTEND = 2'd1,
`ifdef TFL_ALL_RED_EN
      ST_YELLOW = 2'd2,
      ST_CLEAR  = 2'd3
`else
      ST_YELLOW = 2'd2
`endif
   } tfl_state_e;

   // First approach with demand after cur (wrapping modulo n, cur excluded).
   // Scans from the far end so the nearest hit wins; returns cur if none.
   function automatic int unsigned rr_next(input logic [RR_MAX-1:0] dem,
                                           input int unsigned       n,
                                           input int unsigned       cur);
      int unsigned idx;
      rr_next = cur;
      for (int unsigned k = RR_MAX - 1; k >= 1; k--) begin
         if (k < n) begin
            idx = cur + k;
            if (idx >= n) idx = idx - n;
            if (dem[idx[4:0]]) rr_next = idx;
         end
      end
   endfunction

endpackage

// File: rtl/tfl_phase_timer.sv
// tfl_phase_timer: CW-bit phase timer that decrements on tick and reloads
// itself on expiry.
//   clk, reset : clock, asynchronous active-high reset (loads RST_VAL)
//   tick_i     : timebase enable; the counter only moves on tick
//   reload_i   : value (duration-1) loaded on expiry
//   done_c_o   : combinational expiry strobe, tick && count == 0
module tfl_phase_timer #(
   parameter int unsigned   CW      = 8,
   parameter logic [CW-1:0] RST_VAL = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tick_i,
   input  logic [CW-1:0] reload_i,
   output logic          done_c_o
);

   logic [CW-1:0] cnt_q;

   assign done_c_o = tick_i && (cnt_q == '0);

   // Reload on expiry, so the counter never decrements below zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= RST_VAL;
      end else if (done_c_o) begin
         cnt_q <= reload_i;
      end else if (tick_i) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

endmodule

// File: rtl/tfl_multi_phase.sv
// tfl_multi_phase: N-approach round-robin traffic-light controller with
// demand skipping and sensor-driven green extensions.
//   clk, reset : clock, asynchronous active-high reset
//   tick       : one-cycle timebase enable
//   sensor     : per-approach vehicle demand
//   lights     : registered lamps, approach i at [3i+2:3i] = {red,yellow,green}
//   active_idx : registered index of the approach holding right-of-way
//   phase_done : registered one-cycle pulse on every timer expiry
// Configuration macro: TFL_ALL_RED_EN (all-red CLEAR phase between handoffs).
module tfl_multi_phase
   import tfl_pkg::*;
#(
   parameter int unsigned N_APPR    = 4,
   parameter int unsigned GREEN_MIN = 60,
   parameter int unsigned GREEN_EXT = 10,
   parameter int unsigned EXT_MAX   = 3,
   parameter int unsigned YELLOW    = 5,
   parameter int unsigned ALL_RED   = 2,
   parameter int unsigned CW        = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        tick,
   input  logic [N_APPR-1:0]           sensor,
   output logic [3*N_APPR-1:0]         lights,
   output logic [$clog2(N_APPR)-1:0]   active_idx,
   output logic                        phase_done
);

   localparam int unsigned AW = $clog2(N_APPR);
   localparam int unsigned EW = (EXT_MAX < 1) ? 1 : $clog2(EXT_MAX + 1);
   localparam logic [3*N_APPR-1:0] LIGHTS_RST = {{(N_APPR-1){3'b100}}, 3'b001};

   tfl_state_e           state_q, state_d;
   logic [AW-1:0]        active_q, active_d;
   logic [AW-1:0]        next_q, next_d;
   logic [EW-1:0]        ext_q, ext_d;
   logic [3*N_APPR-1:0]  lights_q, lights_d;
   logic                 pd_q;
   logic [CW-1:0]        reload_d;
   logic                 expire_c;
   logic [N_APPR-1:0]    act_oh_c;
   logic                 other_dem_c;
   logic                 own_dem_c;
   logic [2:0]           lamp_act_c;
   logic [2:0]           lamp_idle_c;

   tfl_phase_timer #(
      .CW      (CW),
      .RST_VAL (CW'(GREEN_MIN - 1))
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .tick_i   (tick),
      .reload_i (reload_d),
      .done_c_o (expire_c)
   );

   // Demand split into the active approach and everyone else.
   always_comb begin
      act_oh_c    = N_APPR'(1) << active_q;
      other_dem_c = |(sensor & ~act_oh_c);
      own_dem_c   = |(sensor & act_oh_c);
   end

   // Next-state, handoff bookkeeping, timer reload and lamp decode.
   always_comb begin
      state_d  = state_q;
      active_d = active_q;
      next_d   = next_q;
      ext_d    = ext_q;
      reload_d = CW'(GREEN_MIN - 1);
      lights_d = '0;

      if (expire_c) begin
         case (state_q)
            ST_GREEN, ST_EXTEND: begin
               if (other_dem_c && (!own_dem_c || ext_q == EW'(EXT_MAX))) begin
                  state_d = ST_YELLOW;
                  next_d  = AW'(rr_next(RR_MAX'(sensor), N_APPR, 32'(active_q)));
               end else begin
                  // Extensions are only charged while someone else waits.
                  state_d = ST_EXTEND;
                  if (other_dem_c && ext_q != EW'(EXT_MAX)) ext_d = ext_q + EW'(1);
               end
            end
            ST_YELLOW: begin
`ifdef TFL_ALL_RED_EN
               state_d = ST_CLEAR;
`else
               state_d  = ST_GREEN;
               active_d = next_q;
               ext_d    = '0;
`endif
            end
`ifdef TFL_ALL_RED_EN
            ST_CLEAR: begin
               state_d  = ST_GREEN;
               active_d = next_q;
               ext_d    = '0;
            end
`endif
            default: ;
         endcase
      end

      case (state_d)
         ST_EXTEND: reload_d = CW'(GREEN_EXT - 1);
         ST_YELLOW: reload_d = CW'(YELLOW - 1);
`ifdef TFL_ALL_RED_EN
         ST_CLEAR:  reload_d = CW'(ALL_RED - 1);
`endif
         default:   reload_d = CW'(GREEN_MIN - 1);
      endcase

      lamp_idle_c       = '0;
      lamp_idle_c[LT_R] = 1'b1;
      lamp_act_c        = '0;
      case (state_d)
         ST_GREEN, ST_EXTEND: lamp_act_c[LT_G] = 1'b1;
         ST_YELLOW:           lamp_act_c[LT_Y] = 1'b1;
         default:             lamp_act_c[LT_R] = 1'b1;
      endcase

      for (int unsigned i = 0; i < N_APPR; i++) begin
         lights_d[3*i +: 3] = (AW'(i) == active_d) ? lamp_act_c : lamp_idle_c;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_GREEN;
         active_q <= '0;
         next_q   <= '0;
         ext_q    <= '0;
         lights_q <= LIGHTS_RST;
         pd_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         next_q   <= next_d;
         ext_q    <= ext_d;
         lights_q <= lights_d;
         pd_q     <= expire_c;
      end
   end

   assign lights     = lights_q;
   assign active_idx = active_q;
   assign phase_done = pd_q;

endmodule

// File: tb/tb_tfl_multi_phase.sv
// tb_tfl_multi_phase: directed scenarios plus randomized tick/sensor/reset
// traffic, checked every cycle against a tick-counting model of the
// controller's phase rules.
module tb_tfl_multi_phase;

   localparam int unsigned N    = 4;
   localparam int unsigned GMIN = 4;
   localparam int unsigned GEXT = 2;
   localparam int unsigned EMAX = 2;
   localparam int unsigned YEL  = 2;
   localparam int unsigned AR   = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        tick;
   logic [3:0]  sensor;
   logic [11:0] lights;
   logic [1:0]  active_idx;
   logic        phase_done;

   always #5 clk = ~clk;

   tfl_multi_phase #(
      .N_APPR    (N),
      .GREEN_MIN (GMIN),
      .GREEN_EXT (GEXT),
      .EXT_MAX   (EMAX),
      .YELLOW    (YEL),
      .ALL_RED   (AR),
      .CW        (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .sensor     (sensor),
      .lights     (lights),
      .active_idx (active_idx),
      .phase_done (phase_done)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Model: phase 0 green, 1 extend, 2 yellow, 3 all-red; m_rem = ticks left.
   int m_ph, m_rem, m_ext, m_act, m_nxt;
   bit m_pd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   function automatic logic [11:0] m_lights();
      logic [11:0] l;
      for (int i = 0; i < 4; i++) begin
         if (i != m_act)       l[3*i +: 3] = 3'b100;
         else if (m_ph <= 1)   l[3*i +: 3] = 3'b001;
         else if (m_ph == 2)   l[3*i +: 3] = 3'b010;
         else                  l[3*i +: 3] = 3'b100;
      end
      return l;
   endfunction

   task automatic m_reset();
      m_ph = 0; m_rem = GMIN; m_ext = 0; m_act = 0; m_nxt = 0; m_pd = 1'b0;
   endtask

   task automatic m_handoff();
      m_act = m_nxt; m_ext = 0; m_ph = 0; m_rem = GMIN;
   endtask

   task automatic m_step(input bit tk, input logic [3:0] sen);
      bit other, own, found;
      m_pd = 1'b0;
      if (tk) begin
         m_rem--;
         if (m_rem == 0) begin
            m_pd = 1'b1;
            if (m_ph <= 1) begin
               own   = sen[m_act];
               other = 1'b0;
               for (int j = 0; j < 4; j++) if (j != m_act && sen[j]) other = 1'b1;
               if (other && (!own || m_ext == EMAX)) begin
                  found = 1'b0;
                  for (int k = 1; k < 4; k++) begin
                     if (!found && sen[(m_act + k) % 4]) begin
                        m_nxt = (m_act + k) % 4;
                        found = 1'b1;
                     end
                  end
                  m_ph = 2; m_rem = YEL;
               end else begin
                  if (other && m_ext < EMAX) m_ext++;
                  m_ph = 1; m_rem = GEXT;
               end
            end else if (m_ph == 2) begin
`ifdef TFL_ALL_RED_EN
               m_ph = 3; m_rem = AR;
`else
               m_handoff();
`endif
            end else begin
               m_handoff();
            end
         end
      end
   endtask

   task automatic check_all();
      chk("lights", 32'(lights), 32'(m_lights()));
      chk("active_idx", 32'(active_idx), 32'(m_act));
      chk("phase_done", 32'(phase_done), 32'(m_pd));
   endtask

   // Drive one cycle of inputs, advance the model, compare at the next negedge.
   task automatic cyc(input bit tk, input logic [3:0] sen);
      tick = tk; sensor = sen;
      m_step(tk, sen);
      @(negedge clk);
      check_all();
   endtask

   // Asynchronous reset pulse between clock edges.
   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      m_reset();
      check_all();
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] rs;
      reset = 1'b1; tick = 1'b0; sensor = 4'b0000;
      m_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // S1: no demand -> approach 0 rests green, expiries at 4 then every 2.
      chk("s1_rst_lights", 32'(lights), 32'h0000_0921);
      chk("s1_rst_active", 32'(active_idx), 32'd0);
      chk("s1_rst_pd", 32'(phase_done), 32'd0);
      repeat (3) cyc(1'b1, 4'b0000);
      chk("s1_pd3", 32'(phase_done), 32'd0);
      cyc(1'b1, 4'b0000);
      chk("s1_pd4", 32'(phase_done), 32'd1);
      cyc(1'b1, 4'b0000);
      cyc(1'b1, 4'b0000);
      chk("s1_pd6", 32'(phase_done), 32'd1);
      chk("s1_lights", 32'(lights), 32'(12'b100_100_100_001));

      // S2: demand on 2 only -> 0 green 4, yellow 2, (all-red 1), then 2 green.
      pulse_reset();
      repeat (4) cyc(1'b1, 4'b0100);
      chk("s2_yellow", 32'(lights), 32'(12'b100_100_100_010));
      repeat (2) cyc(1'b1, 4'b0100);
`ifdef TFL_ALL_RED_EN
      chk("s2_allred", 32'(lights), 32'(12'b100_100_100_100));
      cyc(1'b1, 4'b0100);
`endif
      chk("s2_green2", 32'(lights), 32'(12'b100_001_100_100));
      chk("s2_active", 32'(active_idx), 32'd2);

      // S3: 0 and 1 demanding -> 0 green for 8 ticks, then handoff to 1.
      pulse_reset();
      repeat (7) cyc(1'b1, 4'b0011);
      chk("s3_green7", 32'(lights), 32'(12'b100_100_100_001));
      cyc(1'b1, 4'b0011);
      chk("s3_yellow8", 32'(lights), 32'(12'b100_100_100_010));
      repeat (2) cyc(1'b1, 4'b0011);
`ifdef TFL_ALL_RED_EN
      cyc(1'b1, 4'b0011);
`endif
      chk("s3_active", 32'(active_idx), 32'd1);

      // S4: reach approach 3, then demand on 1 only -> 0 skipped across wrap.
      pulse_reset();
      repeat (6) cyc(1'b1, 4'b1000);
`ifdef TFL_ALL_RED_EN
      cyc(1'b1, 4'b1000);
`endif
      chk("s4_active3", 32'(active_idx), 32'd3);
      repeat (4) cyc(1'b1, 4'b0010);
      chk("s4_yellow3", 32'(lights), 32'(12'b010_100_100_100));
      repeat (2) cyc(1'b1, 4'b0010);
`ifdef TFL_ALL_RED_EN
      cyc(1'b1, 4'b0010);
`endif
      chk("s4_active1", 32'(active_idx), 32'd1);
      chk("s4_green1", 32'(lights), 32'(12'b100_100_001_100));

      // S5: reset during approach 2 yellow, then a full 4-tick green.
      pulse_reset();
      repeat (6) cyc(1'b1, 4'b0100);
`ifdef TFL_ALL_RED_EN
      cyc(1'b1, 4'b0100);
`endif
      repeat (4) cyc(1'b1, 4'b0001);
      chk("s5_yellow2", 32'(lights), 32'(12'b100_010_100_100));
      cyc(1'b1, 4'b0001);
      reset = 1'b1;
      #1;
      chk("s5_async_lights", 32'(lights), 32'(12'b100_100_100_001));
      chk("s5_async_active", 32'(active_idx), 32'd0);
      m_reset();
      #1;
      reset = 1'b0;
      repeat (3) cyc(1'b1, 4'b0010);
      chk("s5_pd3", 32'(phase_done), 32'd0);
      cyc(1'b1, 4'b0010);
      chk("s5_pd4", 32'(phase_done), 32'd1);
      chk("s5_yellow0", 32'(lights), 32'(12'b100_100_100_010));

      // S6: tick held low 100 cycles mid-green freezes everything.
      pulse_reset();
      repeat (2) cyc(1'b1, 4'b1110);
      repeat (100) cyc(1'b0, 4'b1110);
      chk("s6_frozen", 32'(lights), 32'(12'b100_100_100_001));
      cyc(1'b1, 4'b1110);
      chk("s6_pd_t3", 32'(phase_done), 32'd0);
      cyc(1'b1, 4'b1110);
      chk("s6_pd_t4", 32'(phase_done), 32'd1);
      chk("s6_yellow0", 32'(lights), 32'(12'b100_100_100_010));

      // Random traffic with sparse ticks, changing demand and stray resets.
      rs = 4'($urandom);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(199) == 0) pulse_reset();
         if ($urandom_range(7) == 0) rs = 4'($urandom);
         cyc($urandom_range(3) != 0, rs);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
